// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order fetch requests,
// buffers returned instructions in a slot queue and hands them to decode.
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_valid,
  input  logic [63:0] jump_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        id_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_addr
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    SLOT_EMPTY,
    SLOT_PENDING,
    SLOT_READY
  } slot_state_e;

  logic [63:0]      pc;
  logic [63:0]      slot_addr  [DEPTH];
  logic [31:0]      slot_inst  [DEPTH];
  slot_state_e      slot_state [DEPTH];
  logic [PTR_W-1:0] alloc_ptr;
  logic [PTR_W-1:0] fill_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] used;
  logic [CNT_W-1:0] drop_cnt;

  logic [CNT_W:0]   occupancy;
  logic [CNT_W-1:0] pending_cnt;
  logic [CNT_W:0]   inflight;
  logic [CNT_W-1:0] next_drop;
  logic [63:0]      jump_pc;
  logic             req_fire;
  logic             take;
  logic             drop_rsp;
  logic             fill_rsp;

  // Request, delivery and response classification for this cycle.
  always_comb begin
    occupancy      = {1'b0, used} + {1'b0, drop_cnt};
    imem_req_valid = ~jump_valid & (occupancy < (CNT_W+1)'(DEPTH));
    req_fire       = imem_req_valid & imem_req_ready;
    inst_valid     = (slot_state[rd_ptr] == SLOT_READY) & ~jump_valid;
    take           = inst_valid & id_ready;
    drop_rsp       = imem_rsp_valid & (drop_cnt != '0);
    fill_rsp       = imem_rsp_valid & (drop_cnt == '0) & (slot_state[fill_ptr] == SLOT_PENDING);
    imem_addr      = pc;
    inst           = slot_inst[rd_ptr];
    inst_addr      = slot_addr[rd_ptr];
    jump_pc        = jump_target & ~64'h3;
  end

  // Responses still owed by memory after a redirect; one arriving now is already accounted.
  always_comb begin
    pending_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_state[PTR_W'(i)] == SLOT_PENDING) begin
        pending_cnt = pending_cnt + CNT_W'(1);
      end
    end
    inflight = {1'b0, pending_cnt} + {1'b0, drop_cnt};
    if (imem_rsp_valid && (inflight != '0)) begin
      next_drop = CNT_W'(inflight - (CNT_W+1)'(1));
    end else begin
      next_drop = CNT_W'(inflight);
    end
  end

  // PC, slot queue, pointers and stale-response counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      drop_cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_state[PTR_W'(i)] <= SLOT_EMPTY;
        slot_addr[PTR_W'(i)]  <= '0;
        slot_inst[PTR_W'(i)]  <= '0;
      end
    end else if (jump_valid) begin
      pc        <= jump_pc;
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      rd_ptr    <= '0;
      used      <= '0;
      drop_cnt  <= next_drop;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        slot_state[PTR_W'(i)] <= SLOT_EMPTY;
      end
    end else begin
      if (drop_rsp) begin
        drop_cnt <= drop_cnt - CNT_W'(1);
      end
      if (fill_rsp) begin
        slot_inst[fill_ptr]  <= imem_rdata;
        slot_state[fill_ptr] <= SLOT_READY;
        fill_ptr             <= fill_ptr + PTR_W'(1);
      end
      if (req_fire) begin
        slot_addr[alloc_ptr]  <= pc;
        slot_state[alloc_ptr] <= SLOT_PENDING;
        alloc_ptr             <= alloc_ptr + PTR_W'(1);
        pc                    <= pc + 64'd4;
      end
      if (take) begin
        slot_state[rd_ptr] <= SLOT_EMPTY;
        rd_ptr             <= rd_ptr + PTR_W'(1);
      end
      used <= used + CNT_W'(req_fire) - CNT_W'(take);
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: latency-programmable in-order memory, request-address
// model feeding an expected-delivery queue, and a decoupled delivery monitor.
module tb_if_stage;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_valid = 1'b0;
  logic [63:0] jump_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        id_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_addr;

  if_stage #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_valid     (jump_valid),
    .jump_target    (jump_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .id_ready       (id_ready),
    .inst           (inst),
    .inst_addr      (inst_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mem_lat = 1;
  int req_cnt = 0;
  int delivered = 0;
  logic [63:0] exp_req_pc = RST_PC;
  logic [63:0] sb[$];
  logic [63:0] exp_addr;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], 16'h0013};
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory response driver: head of the in-order queue once its latency has elapsed.
  always @(posedge clk) begin
    #1;
    if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = mem_data(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = '0;
    end
  end

  // Memory request side plus request-address model.
  always @(negedge clk) begin
    if (!rst) begin
      mq.delete();
    end else begin
      if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        check64("req_addr", imem_addr, exp_req_pc);
        mq.push_back('{addr: imem_addr, due: cyc + mem_lat});
        sb.push_back(exp_req_pc);
        exp_req_pc = exp_req_pc + 64'd4;
        req_cnt++;
      end
    end
  end

  // Delivery monitor.
  always @(negedge clk) begin
    if (rst && inst_valid && id_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL deliver_unexpected actual=%h required=none", inst_addr);
      end else begin
        exp_addr = sb.pop_front();
        check64("inst_addr", inst_addr, exp_addr);
        check64("inst", 64'(inst), 64'(mem_data(exp_addr)));
        delivered++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    #2;
    rst = 1'b0;
    sb.delete();
    exp_req_pc = RST_PC;
    next_cycle();
    next_cycle();
  endtask

  task automatic redirect(input logic [63:0] tgt);
    jump_valid  = 1'b1;
    jump_target = tgt;
    sb.delete();
    exp_req_pc  = tgt & ~64'h3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (2) next_cycle();
    check64("rst_inst_valid", 64'(inst_valid), 64'd0);
    check64("rst_imem_addr", imem_addr, RST_PC);

    // Reset release, L=1 streaming
    id_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 1; rst = 1'b1;
    mid();
    check64("req_valid_c0", 64'(imem_req_valid), 64'd1);
    check64("lat_c0", 64'(inst_valid), 64'd0);
    mid();
    check64("lat_c1", 64'(inst_valid), 64'd0);
    mid();
    check64("lat_c2", 64'(inst_valid), 64'd1);
    check64("lat_c2_addr", inst_addr, RST_PC);
    repeat (8) begin
      mid();
      check64("stream_valid", 64'(inst_valid), 64'd1);
    end

    // Decode stalled: queue fills after exactly DEPTH requests
    reset_pulse();
    id_ready = 1'b0; imem_req_ready = 1'b1; mem_lat = 1; req_cnt = 0; rst = 1'b1;
    repeat (10) mid();
    check64("full_req_cnt", 64'(req_cnt), 64'd4);
    check64("full_req_valid", 64'(imem_req_valid), 64'd0);
    check64("full_imem_addr", imem_addr, RST_PC + 64'd16);
    check64("full_head_valid", 64'(inst_valid), 64'd1);
    check64("full_head_addr", inst_addr, RST_PC);
    next_cycle();
    d0 = delivered;
    id_ready = 1'b1;
    repeat (12) next_cycle();
    check64("drain_progress", 64'(delivered - d0 >= 8), 64'd1);

    // Redirect with requests in flight, L=3
    reset_pulse();
    id_ready = 1'b0; imem_req_ready = 1'b1; mem_lat = 3; rst = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    redirect(64'h0000_0000_8000_1002);
    id_ready = 1'b1;
    mid();
    check64("jump_no_deliver", 64'(inst_valid), 64'd0);
    check64("jump_no_req", 64'(imem_req_valid), 64'd0);
    next_cycle();
    jump_valid = 1'b0;
    mid();
    check64("redir_addr", imem_addr, 64'h0000_0000_8000_1000);
    check64("redir_req_valid", 64'(imem_req_valid), 64'd1);
    for (int k = 4; k < 8; k++) begin
      if (k != 4) mid();
      check64("redir_wait", 64'(inst_valid), 64'd0);
      next_cycle();
    end
    mid();
    check64("redir_first_valid", 64'(inst_valid), 64'd1);
    check64("redir_first_addr", inst_addr, 64'h0000_0000_8000_1000);
    repeat (10) next_cycle();

    // Redirect colliding with a response and a decode take, L=1
    mem_lat = 1;
    repeat (10) next_cycle();
    mid();
    check64("pre_jump_valid", 64'(inst_valid), 64'd1);
    next_cycle();
    redirect(64'h0000_0000_8000_2000);
    mid();
    check64("collide_no_deliver", 64'(inst_valid), 64'd0);
    next_cycle();
    jump_valid = 1'b0;
    mid();
    check64("collide_addr", imem_addr, 64'h0000_0000_8000_2000);
    check64("collide_n1", 64'(inst_valid), 64'd0);
    mid();
    check64("collide_n2", 64'(inst_valid), 64'd0);
    mid();
    check64("collide_n3_valid", 64'(inst_valid), 64'd1);
    check64("collide_n3_addr", inst_addr, 64'h0000_0000_8000_2000);
    repeat (6) next_cycle();

    // Random request back-pressure and decode stalls, L=2
    mem_lat = 2;
    d0 = delivered;
    repeat (200) begin
      next_cycle();
      imem_req_ready = 1'($urandom_range(0, 1));
      id_ready       = ($urandom_range(0, 3) != 0);
    end
    next_cycle();
    imem_req_ready = 1'b1; id_ready = 1'b1;
    repeat (10) next_cycle();
    check64("random_progress", 64'(delivered - d0 >= 40), 64'd1);

    // Reset mid-operation with two READY slots and one PENDING
    reset_pulse();
    id_ready = 1'b0; imem_req_ready = 1'b1; mem_lat = 2; req_cnt = 0; rst = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    imem_req_ready = 1'b0;
    next_cycle();
    mid();
    check64("pre_rst_req_cnt", 64'(req_cnt), 64'd3);
    check64("pre_rst_valid", 64'(inst_valid), 64'd1);
    check64("pre_rst_imem_addr", imem_addr, RST_PC + 64'd12);
    rst = 1'b0;
    sb.delete();
    exp_req_pc = RST_PC;
    #1;
    check64("rst_mid_valid", 64'(inst_valid), 64'd0);
    check64("rst_mid_addr", imem_addr, RST_PC);
    next_cycle();
    next_cycle();
    d0 = delivered;
    imem_req_ready = 1'b1; id_ready = 1'b1; rst = 1'b1;
    repeat (10) next_cycle();
    check64("post_rst_progress", 64'(delivered - d0 >= 6), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
